// File: rtl/brainfuck_constants.sv
// Shared Brainfuck definitions: opcode encoding, ASCII command decode and
// the program-loader state codes.
package brainfuck_constants;

  typedef enum logic [2:0] {
    OP_INC_PTR = 3'd0,
    OP_DEC_PTR = 3'd1,
    OP_INC     = 3'd2,
    OP_DEC     = 3'd3,
    OP_OUT     = 3'd4,
    OP_IN      = 3'd5,
    OP_JZ      = 3'd6,
    OP_JNZ     = 3'd7
  } bf_opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ECHO  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  typedef struct packed {
    logic       valid;
    bf_opcode_e op;
  } bf_decode_t;

  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_LT    = 8'h3C;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_RBRK  = 8'h5D;

  function automatic bf_decode_t bf_decode(input logic [7:0] ch);
    bf_decode_t r;
    r.valid = 1'b1;
    r.op    = OP_INC_PTR;
    case (ch)
      CH_GT:    r.op = OP_INC_PTR;
      CH_LT:    r.op = OP_DEC_PTR;
      CH_PLUS:  r.op = OP_INC;
      CH_MINUS: r.op = OP_DEC;
      CH_DOT:   r.op = OP_OUT;
      CH_COMMA: r.op = OP_IN;
      CH_LBRK:  r.op = OP_JZ;
      CH_RBRK:  r.op = OP_JNZ;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bf_char_decoder.sv
// Combinational byte classifier: command opcode, bracket flags and the
// load terminator. The terminator is never reported as a command.
module bf_char_decoder
  import brainfuck_constants::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] TERMINATOR = 8'h21
) (
  input  logic [DATA_WIDTH-1:0] char_i,
  output logic                  valid_o,
  output bf_opcode_e            opcode_o,
  output logic                  is_open_o,
  output logic                  is_close_o,
  output logic                  is_term_o
);

  logic [7:0] ch;
  logic       in_range;
  bf_decode_t dec;

  // Bytes wider than ASCII only match when the upper bits are clear.
  assign ch       = 8'(char_i);
  assign in_range = (DATA_WIDTH'(ch) == char_i);
  assign dec      = bf_decode(ch);

  assign is_term_o  = in_range && (ch == TERMINATOR);
  assign valid_o    = in_range && dec.valid && !is_term_o;
  assign opcode_o   = dec.op;
  assign is_open_o  = valid_o && (dec.op == OP_JZ);
  assign is_close_o = valid_o && (dec.op == OP_JNZ);

endmodule

// File: rtl/bf_prog_loader.sv
// Streams Brainfuck source from the UART receiver into program memory,
// holding the core in reset until a bracket-balanced program is loaded.
module bf_prog_loader
  import brainfuck_constants::*;
#(
  parameter int         PROG_ADDR_WIDTH = 8,
  parameter int         PROG_DATA_WIDTH = 3,
  parameter int         DATA_WIDTH      = 8,
  parameter bit         ECHO            = 1'b1,
  parameter logic [7:0] TERMINATOR      = 8'h21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_ready,
  output logic                       rx_clear,
  output logic [DATA_WIDTH-1:0]      tx_data,
  output logic                       tx_wr,
  input  logic                       tx_busy,
  output logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
  output logic [PROG_DATA_WIDTH-1:0] prog_wr_data,
  output logic                       prog_wr_en,
  output logic [PROG_ADDR_WIDTH:0]   prog_len,
  output logic                       load_done,
  output logic                       load_error,
  output logic                       core_hold,
  output logic [2:0]                 debug_state
);

  localparam int              CNT_W    = PROG_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

  loader_state_e              state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           depth_q, depth_d;
  logic                       rx_clear_q, rx_clear_d;
  logic                       tx_wr_q, tx_wr_d;
  logic                       wr_en_q, wr_en_d;
  logic [PROG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic                       hold_q, hold_d;
  logic [PROG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]      tx_data_q, tx_data_d;

  logic       cmd_valid;
  bf_opcode_e cmd_op;
  logic       cmd_open;
  logic       cmd_close;
  logic       cmd_term;
  logic       accept;

  bf_char_decoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .TERMINATOR (TERMINATOR)
  ) u_decoder (
    .char_i     (rx_data),
    .valid_o    (cmd_valid),
    .opcode_o   (cmd_op),
    .is_open_o  (cmd_open),
    .is_close_o (cmd_close),
    .is_term_o  (cmd_term)
  );

  // rx_clear_q is only high in LOAD, so this is the sole consume point.
  assign accept = rx_ready && rx_clear_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    depth_d   = depth_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;

    if (start) begin
      state_d = ST_LOAD;
      count_d = '0;
      depth_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (cmd_term) begin
              state_d = (depth_q == '0) ? ST_DONE : ST_ERROR;
            end else if (cmd_close && (depth_q == '0)) begin
              state_d = ST_ERROR;
            end else if (cmd_valid) begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q[PROG_ADDR_WIDTH-1:0];
              wr_data_d = PROG_DATA_WIDTH'(cmd_op);
              count_d   = count_q + 1'b1;
              if (cmd_open)
                depth_d = depth_q + 1'b1;
              else if (cmd_close)
                depth_d = depth_q - 1'b1;
              if (ECHO) begin
                tx_data_d = rx_data;
                state_d   = ST_ECHO;
              end else if (count_d == CAPACITY) begin
                state_d = (depth_d == '0) ? ST_DONE : ST_ERROR;
              end
            end
          end
        end
        ST_ECHO: begin
          // Memory-full resolution waits until the last character is echoed.
          if (!tx_busy) begin
            tx_wr_d = 1'b1;
            if (count_q == CAPACITY)
              state_d = (depth_q == '0) ? ST_DONE : ST_ERROR;
            else
              state_d = ST_LOAD;
          end
        end
        default: ;
      endcase
    end

    rx_clear_d = (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
    hold_d     = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      depth_q    <= '0;
      rx_clear_q <= 1'b0;
      tx_wr_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      depth_q    <= depth_d;
      rx_clear_q <= rx_clear_d;
      tx_wr_q    <= tx_wr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      done_q     <= done_d;
      error_q    <= error_d;
      hold_q     <= hold_d;
    end
  end

  // Payload registers are qualified by their strobes and need no reset.
  always_ff @(posedge clk) begin
    wr_data_q <= wr_data_d;
    tx_data_q <= tx_data_d;
  end

  assign rx_clear     = rx_clear_q;
  assign tx_data      = tx_data_q;
  assign tx_wr        = tx_wr_q;
  assign prog_wr_addr = wr_addr_q;
  assign prog_wr_data = wr_data_q;
  assign prog_wr_en   = wr_en_q;
  assign prog_len     = count_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign core_hold    = hold_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_bf_prog_loader.sv
// Bench for bf_prog_loader: three configurations (8-bit no echo, 2-bit no
// echo, 8-bit echo) checked against a string-level model of the loader.
module tb_bf_prog_loader;

  localparam int NI   = 3;
  localparam int MAXB = 320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] rx_data_r  [NI];
  logic       rx_ready_r [NI];
  logic       start_r    [NI];
  logic       tx_busy_r  [NI];

  logic       rx_clear_w [NI];
  logic       tx_wr_w    [NI];
  logic       wr_en_w    [NI];
  logic       done_w     [NI];
  logic       err_w      [NI];
  logic       hold_w     [NI];
  logic [7:0] tx_data_w  [NI];
  logic [7:0] addr_w     [NI];
  logic [2:0] data_w     [NI];
  logic [2:0] ds_w       [NI];
  logic [8:0] len_w      [NI];
  logic [1:0] addr1;
  logic [2:0] len1;

  assign addr_w[1] = {6'd0, addr1};
  assign len_w[1]  = {6'd0, len1};

  bf_prog_loader #(.PROG_ADDR_WIDTH(8), .ECHO(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .start(start_r[0]), .rx_data(rx_data_r[0]),
    .rx_ready(rx_ready_r[0]), .rx_clear(rx_clear_w[0]), .tx_data(tx_data_w[0]),
    .tx_wr(tx_wr_w[0]), .tx_busy(tx_busy_r[0]), .prog_wr_addr(addr_w[0]),
    .prog_wr_data(data_w[0]), .prog_wr_en(wr_en_w[0]), .prog_len(len_w[0]),
    .load_done(done_w[0]), .load_error(err_w[0]), .core_hold(hold_w[0]),
    .debug_state(ds_w[0]));

  bf_prog_loader #(.PROG_ADDR_WIDTH(2), .ECHO(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .start(start_r[1]), .rx_data(rx_data_r[1]),
    .rx_ready(rx_ready_r[1]), .rx_clear(rx_clear_w[1]), .tx_data(tx_data_w[1]),
    .tx_wr(tx_wr_w[1]), .tx_busy(tx_busy_r[1]), .prog_wr_addr(addr1),
    .prog_wr_data(data_w[1]), .prog_wr_en(wr_en_w[1]), .prog_len(len1),
    .load_done(done_w[1]), .load_error(err_w[1]), .core_hold(hold_w[1]),
    .debug_state(ds_w[1]));

  bf_prog_loader #(.PROG_ADDR_WIDTH(8), .ECHO(1'b1)) u_echo (
    .clk(clk), .rst(rst), .start(start_r[2]), .rx_data(rx_data_r[2]),
    .rx_ready(rx_ready_r[2]), .rx_clear(rx_clear_w[2]), .tx_data(tx_data_w[2]),
    .tx_wr(tx_wr_w[2]), .tx_busy(tx_busy_r[2]), .prog_wr_addr(addr_w[2]),
    .prog_wr_data(data_w[2]), .prog_wr_en(wr_en_w[2]), .prog_len(len_w[2]),
    .load_done(done_w[2]), .load_error(err_w[2]), .core_hold(hold_w[2]),
    .debug_state(ds_w[2]));

  // Reference model: expected writes, echoes, consumption and final state.
  string      cmds = "><+-.,[]";
  logic [7:0] stim [MAXB];
  int         stim_n;
  logic [2:0] exp_op [NI][MAXB];
  logic [7:0] exp_ch [NI][MAXB];
  int         exp_nw [NI], exp_ne [NI], exp_cons [NI], exp_len [NI], exp_fin [NI];
  int         wr_ptr [NI], tx_ptr [NI];
  int         cfg_aw [NI] = '{8, 2, 8};
  bit         cfg_echo [NI] = '{1'b0, 1'b0, 1'b1};
  int         busy_force;
  bit         busy_rand;
  int         nchk, nerr;

  function automatic void chk(string nm, int i, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endfunction

  function automatic int op_of(logic [7:0] c);
    for (int k = 0; k < 8; k++)
      if (cmds[k] == c) return k;
    return -1;
  endfunction

  task automatic model(int i);
    int depth, cnt, cap, op;
    depth = 0; cnt = 0; cap = 1 << cfg_aw[i];
    exp_ne[i] = 0; exp_cons[i] = 0; exp_fin[i] = 1;
    for (int k = 0; k < stim_n; k++) begin
      op = op_of(stim[k]);
      exp_cons[i]++;
      if (stim[k] == 8'h21) begin exp_fin[i] = (depth == 0) ? 3 : 4; break; end
      if (op < 0) continue;
      if (op == 7 && depth == 0) begin exp_fin[i] = 4; break; end
      exp_op[i][cnt] = op[2:0];
      if (cfg_echo[i]) begin exp_ch[i][exp_ne[i]] = stim[k]; exp_ne[i]++; end
      cnt++;
      if (op == 6) depth++;
      if (op == 7) depth--;
      if (cnt == cap) begin exp_fin[i] = (depth == 0) ? 3 : 4; break; end
    end
    exp_nw[i]  = cnt;
    exp_len[i] = cnt;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst || start_r[i]) begin wr_ptr[i] = 0; tx_ptr[i] = 0; end
        if (wr_en_w[i]) begin
          chk("write_expected", i, int'(wr_ptr[i] < exp_nw[i]), 1);
          if (wr_ptr[i] < exp_nw[i]) begin
            chk("wr_addr", i, addr_w[i], wr_ptr[i]);
            chk("wr_data", i, data_w[i], exp_op[i][wr_ptr[i]]);
          end
          wr_ptr[i]++;
        end
        if (tx_wr_w[i]) begin
          chk("echo_expected", i, int'(tx_ptr[i] < exp_ne[i]), 1);
          chk("echo_while_idle", i, tx_busy_r[i], 0);
          if (tx_ptr[i] < exp_ne[i])
            chk("tx_data", i, tx_data_w[i], exp_ch[i][tx_ptr[i]]);
          tx_ptr[i]++;
        end
        chk("prog_len", i, len_w[i], wr_ptr[i]);
        chk("core_hold", i, hold_w[i], int'(ds_w[i] != 3'd3));
        chk("load_done", i, done_w[i], int'(ds_w[i] == 3'd3));
        chk("load_error", i, err_w[i], int'(ds_w[i] == 3'd4));
        chk("rx_clear_state", i, rx_clear_w[i], int'(ds_w[i] == 3'd1));
        if (cfg_echo[i] && tx_ptr[i] < wr_ptr[i])
          chk("rx_held_for_echo", i, rx_clear_w[i], 0);
      end
      for (int i = 0; i < NI; i++) begin
        if (cfg_echo[i] && busy_force > 0) tx_busy_r[i] = 1'b1;
        else tx_busy_r[i] = cfg_echo[i] && busy_rand && ($urandom % 3 == 0);
      end
      if (busy_force > 0) busy_force--;
    end
  endtask

  task automatic load_str(string s);
    stim_n = s.len();
    for (int k = 0; k < stim_n; k++) stim[k] = s[k];
  endtask

  task automatic pulse_start(int i);
    start_r[i] = 1'b1;
    @(negedge clk); #1;
    start_r[i] = 1'b0;
  endtask

  task automatic send_byte(int i, logic [7:0] b, output bit ok);
    int t;
    t = 0;
    if ($urandom % 4 == 0) repeat ($urandom_range(3, 1)) begin @(negedge clk); #1; end
    rx_data_r[i]  = b;
    rx_ready_r[i] = 1'b1;
    while (!rx_clear_w[i] && t < 40) begin @(negedge clk); #1; t++; end
    ok = rx_clear_w[i];
    if (ok) begin @(negedge clk); #1; end
    rx_ready_r[i] = 1'b0;
  endtask

  task automatic run_case(int i, string nm);
    int cons;
    bit ok;
    cons = 0;
    model(i);
    pulse_start(i);
    for (int k = 0; k < stim_n; k++) begin
      send_byte(i, stim[k], ok);
      if (!ok) break;
      cons++;
    end
    busy_rand = 1'b0;
    repeat (30) begin @(negedge clk); #1; end
    chk({nm, "_consumed"}, i, cons, exp_cons[i]);
    chk({nm, "_writes"}, i, wr_ptr[i], exp_nw[i]);
    chk({nm, "_echoes"}, i, tx_ptr[i], exp_ne[i]);
    chk({nm, "_state"}, i, ds_w[i], exp_fin[i]);
    chk({nm, "_len"}, i, len_w[i], exp_len[i]);
    chk({nm, "_rx_clear"}, i, rx_clear_w[i], int'(exp_fin[i] == 1));
  endtask

  task automatic check_reset_outputs(string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_state"}, i, ds_w[i], 0);
      chk({nm, "_rx_clear"}, i, rx_clear_w[i], 0);
      chk({nm, "_tx_wr"}, i, tx_wr_w[i], 0);
      chk({nm, "_wr_en"}, i, wr_en_w[i], 0);
      chk({nm, "_addr"}, i, addr_w[i], 0);
      chk({nm, "_len"}, i, len_w[i], 0);
      chk({nm, "_done"}, i, done_w[i], 0);
      chk({nm, "_error"}, i, err_w[i], 0);
      chk({nm, "_hold"}, i, hold_w[i], 1);
    end
  endtask

  int pin_ops [7] = '{2, 6, 3, 0, 2, 1, 7};

  initial begin
    bit ok;
    int n, pick, inst;
    rst = 1'b0;
    busy_force = 0;
    busy_rand = 1'b0;
    nchk = 0;
    nerr = 0;
    for (int i = 0; i < NI; i++) begin
      rx_data_r[i] = 8'h00; rx_ready_r[i] = 1'b0; start_r[i] = 1'b0; tx_busy_r[i] = 1'b0;
      exp_nw[i] = 0; exp_ne[i] = 0; wr_ptr[i] = 0; tx_ptr[i] = 0;
    end
    fork
      compare_loop();
    join_none
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("por");

    // Hand-computed pins on the model itself.
    load_str("+[->+<]!");
    model(0);
    chk("pin_nw", 0, exp_nw[0], 7);
    chk("pin_fin", 0, exp_fin[0], 3);
    for (int k = 0; k < 7; k++) chk("pin_op", k, exp_op[0][k], pin_ops[k]);

    run_case(0, "basic");
    chk("basic_len_lit", 0, len_w[0], 7);
    chk("basic_hold_lit", 0, hold_w[0], 0);
    chk("basic_done_lit", 0, done_w[0], 1);

    load_str("a+ b\n-!");
    run_case(0, "junk");
    chk("junk_len_lit", 0, len_w[0], 2);

    load_str("+]");
    run_case(0, "close0");
    chk("close0_err_lit", 0, err_w[0], 1);
    chk("close0_hold_lit", 0, hold_w[0], 1);

    load_str("[[]!");
    run_case(0, "unbal");
    chk("unbal_len_lit", 0, len_w[0], 3);
    chk("unbal_state_lit", 0, ds_w[0], 4);

    load_str("!");
    run_case(0, "empty");
    chk("empty_state_lit", 0, ds_w[0], 3);

    load_str("+-><+");
    run_case(1, "full4");
    chk("full4_len_lit", 1, len_w[1], 4);
    chk("full4_rx_clear_lit", 1, rx_clear_w[1], 0);
    chk("full4_cons_lit", 1, exp_cons[1], 4);

    load_str("[+++");
    run_case(1, "full4_open");
    chk("full4_open_state_lit", 1, ds_w[1], 4);

    stim[0] = 8'h5B;
    for (int k = 1; k < 257; k++) stim[k] = 8'h2B;
    stim_n = 257;
    run_case(0, "full256_open");
    chk("full256_len_lit", 0, len_w[0], 256);

    load_str("+.");
    busy_force = 12;
    run_case(2, "echo_busy");
    chk("echo_busy_count_lit", 2, tx_ptr[2], 2);

    // A start coinciding with a valid byte must win.
    load_str("++");
    run_case(0, "pre_restart");
    exp_nw[0] = 0;
    rx_data_r[0] = 8'h2B;
    rx_ready_r[0] = 1'b1;
    pulse_start(0);
    rx_ready_r[0] = 1'b0;
    repeat (5) begin @(negedge clk); #1; end
    chk("restart_len", 0, len_w[0], 0);
    chk("restart_state", 0, ds_w[0], 1);

    for (int r = 0; r < 24; r++) begin
      inst = $urandom_range(2, 0);
      n = $urandom_range(40, 1);
      for (int k = 0; k < n; k++) begin
        pick = $urandom % 16;
        if (pick < 8) stim[k] = cmds[pick];
        else if (pick < 10) stim[k] = 8'h2B;
        else if (pick < 11) stim[k] = 8'h5B;
        else if (pick < 14) stim[k] = 8'($urandom_range(8'h7E, 8'h20));
        else if (pick < 15) stim[k] = 8'h21;
        else stim[k] = 8'h0A;
      end
      stim_n = n;
      if ($urandom % 2 == 0) begin stim[n] = 8'h21; stim_n = n + 1; end
      busy_rand = 1'b1;
      run_case(inst, "rand");
    end

    // Asynchronous reset in the middle of a load.
    load_str("++[");
    model(0);
    pulse_start(0);
    for (int k = 0; k < stim_n; k++) send_byte(0, stim[k], ok);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = 0; i < NI; i++) begin exp_nw[i] = 0; exp_ne[i] = 0; end
    @(negedge clk); #1 rst = 1'b1;
    repeat (10) begin @(negedge clk); #1; end
    check_reset_outputs("after_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
